// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state type, defaults and helpers for the system bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        HANDOVER = 2'd2
    } arb_state_e;

    localparam int NUM_MASTERS_DEFAULT = 3;
    localparam int TIMEOUT_DEFAULT     = 4095;
    localparam int BRIDGE_MASTER       = 2;

    // Index width that stays legal even for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin winner picker with forced override
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N  = NUM_MASTERS_DEFAULT,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last,
    input  logic          forced_valid,
    input  logic [IW-1:0] forced_idx,
    output logic [N-1:0]  winner,
    output logic          valid
);

    // A forced index wins outright; otherwise take the first eligible bit after last, wrapping
    always_comb begin
        logic [IW-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = last;
        if (forced_valid) begin
            winner[forced_idx] = 1'b1;
            valid              = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
                if (!valid && eligible[idx]) begin
                    winner[idx] = 1'b1;
                    valid       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with dead-cycle handover and hold timeout; split parking under BUS_ARB_SPLIT_EN
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEFAULT,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                              clock,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS-1:0]            release_pulse,
    input  logic                              split,
    input  logic                              split_ready,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [idx_width(NUM_MASTERS)-1:0] msel,
    output logic                              bus_busy,
    output logic                              timeout_err
);

    localparam int            IW         = idx_width(NUM_MASTERS);
    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_MAX   = CW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_MASTERS - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          msel_q, msel_d;
    logic                   busy_q, busy_d;
    logic                   terr_q, terr_d;
    logic [IW-1:0]          last_q, last_d;
    logic [CW-1:0]          hold_q, hold_d;
    logic [NUM_MASTERS-1:0] parked_q;
    logic                   resumable_q;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          parked_idx;
    logic                   forced_valid;
    logic                   split_allowed;
    logic                   owner_done;
    logic                   timeout_hit;
    logic                   split_hit;
    logic                   take_grant;
    logic                   leave_owned;

    // A resumable parked master jumps the queue only while it still requests
    assign eligible     = req & ~parked_q;
    assign forced_valid = resumable_q && ((req & parked_q) != '0);

    rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .eligible     (eligible),
        .last         (last_q),
        .forced_valid (forced_valid),
        .forced_idx   (parked_idx),
        .winner       (pick_oh),
        .valid        (pick_valid)
    );

    // One-hot to binary for the picked winner and the parked master
    always_comb begin
        pick_idx   = '0;
        parked_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IW'(i);
            end
            if (parked_q[i]) begin
                parked_idx = IW'(i);
            end
        end
    end

    // Owner exit conditions, highest priority first: release/req-drop, timeout, split
    always_comb begin
        owner_done  = 1'b0;
        timeout_hit = 1'b0;
        split_hit   = 1'b0;
        if (state_q == OWNED) begin
            if (release_pulse[msel_q] || !req[msel_q]) begin
                owner_done = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
                timeout_hit = 1'b1;
            end else if (split_allowed) begin
                split_hit = 1'b1;
            end
        end
    end

    assign leave_owned = owner_done || timeout_hit || split_hit;
    assign take_grant  = (state_q != OWNED) && pick_valid;

    // FSM state register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE and HANDOVER both run selection; HANDOVER only exists for the dead cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HANDOVER: state_d = pick_valid ? OWNED : IDLE;
            OWNED:          state_d = leave_owned ? HANDOVER : OWNED;
            default:        state_d = IDLE;
        endcase
    end

    // FSM outputs: load a new owner, hold it, or drop to no grant; hold counter saturates
    always_comb begin
        grant_d = grant_q;
        msel_d  = msel_q;
        hold_d  = hold_q;
        last_d  = last_q;
        terr_d  = timeout_hit;
        if (take_grant) begin
            grant_d = pick_oh;
            msel_d  = pick_idx;
            hold_d  = '0;
            last_d  = pick_idx;
        end else if (state_q == OWNED) begin
            if (leave_owned) begin
                grant_d = '0;
                msel_d  = '0;
            end
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            grant_d = '0;
            msel_d  = '0;
        end
        busy_d = (grant_d != '0);
    end

    // Registered outputs and round-robin bookkeeping
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            msel_q  <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            last_q  <= LAST_RESET;
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            msel_q  <= msel_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

`ifdef BUS_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] parked_d;
    logic                   resumable_d;

    // Only one master can be parked at a time; further splits leave the owner in place
    assign split_allowed = split && (parked_q == '0);

    // Park on split, mark resumable on ready, unpark on forced grant or when it stops requesting
    always_comb begin
        parked_d    = parked_q;
        resumable_d = resumable_q;
        if (split_hit) begin
            parked_d    = grant_q;
            resumable_d = 1'b0;
        end
        if (split_ready && (parked_q != '0)) begin
            resumable_d = 1'b1;
        end
        if (resumable_q && ((req & parked_q) == '0)) begin
            parked_d    = '0;
            resumable_d = 1'b0;
        end
        if (take_grant && forced_valid) begin
            parked_d    = '0;
            resumable_d = 1'b0;
        end
    end

    // Parking state register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            parked_q    <= '0;
            resumable_q <= 1'b0;
        end else begin
            parked_q    <= parked_d;
            resumable_q <= resumable_d;
        end
    end
`else
    logic unused_split_inputs;

    assign parked_q            = '0;
    assign resumable_q         = 1'b0;
    assign split_allowed       = 1'b0;
    assign unused_split_inputs = split ^ split_ready;
`endif

    assign grant       = grant_q;
    assign msel        = msel_q;
    assign bus_busy    = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against an ownership-level model
module tb_bus_arbiter;

    localparam int N       = 3;
    localparam int TIMEOUT = 4095;
`ifdef BUS_ARB_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic       clock;
    logic       rst;
    logic [2:0] req;
    logic [2:0] rel;
    logic       split;
    logic       split_ready;
    logic [2:0] grant;
    logic [1:0] msel;
    logic       bus_busy;
    logic       timeout_err;

    int n_vec;
    int n_err;

    // model: who owns the bus (-1 = nobody), how long, who won last, who is parked
    int m_owner;
    int m_hold;
    int m_last;
    int m_parked;
    bit m_resume;
    bit m_terr;

    int n_hi;
    int n_terr;
    int seen;
    int held;

    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] exp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    bus_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .req           (req),
        .release_pulse (rel),
        .split         (split),
        .split_ready   (split_ready),
        .grant         (grant),
        .msel          (msel),
        .bus_busy      (bus_busy),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit has(input logic [2:0] v, input int i);
        return ((v >> i) & 3'b001) != 3'b000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        int  o_owner;
        int  o_parked;
        bit  o_res;
        int  w;
        o_owner  = m_owner;
        o_parked = m_parked;
        o_res    = m_resume;
        m_terr   = 1'b0;
        if (!rst) begin
            m_owner  = -1;
            m_hold   = 0;
            m_last   = N - 1;
            m_parked = -1;
            m_resume = 1'b0;
            return;
        end
        if (o_owner >= 0) begin
            if (has(rel, o_owner) || !has(req, o_owner)) begin
                m_owner = -1;
            end else if (m_hold == TIMEOUT) begin
                m_owner = -1;
                m_terr  = 1'b1;
            end else if (SPLIT_EN && split && o_parked < 0) begin
                m_parked = o_owner;
                m_resume = 1'b0;
                m_owner  = -1;
            end else begin
                m_hold++;
            end
        end else begin
            w = -1;
            if (o_res && o_parked >= 0 && has(req, o_parked)) begin
                w        = o_parked;
                m_parked = -1;
                m_resume = 1'b0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (w < 0 && has(req, c) && c != o_parked) w = c;
                end
            end
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
                m_last  = w;
            end
        end
        if (SPLIT_EN && split_ready && o_parked >= 0 && m_parked >= 0) m_resume = 1'b1;
        if (o_res && o_parked >= 0 && !has(req, o_parked)) begin
            m_parked = -1;
            m_resume = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [2:0] eg;
        logic [1:0] em;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        em = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
        check_val("grant", 32'(grant), 32'(eg));
        check_val("msel", 32'(msel), 32'(em));
        check_val("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
        check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later, pulses cleared
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
        rel         = 3'b000;
        split       = 1'b0;
        split_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_owner = -1; m_hold = 0; m_last = N - 1; m_parked = -1; m_resume = 1'b0; m_terr = 1'b0;
        rst = 1'b0; req = 3'b000; rel = 3'b000; split = 1'b0; split_ready = 1'b0;

        // reset state
        cycle();
        cycle();
        check_val("reset_grant", 32'(grant), 32'h0);
        check_val("reset_msel", 32'(msel), 32'h0);
        rst = 1'b1;
        cycle();

        // all three request, each owner releases after holding two cycles
        req  = 3'b111;
        seen = 0;
        held = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            cycle();
            if (m_owner >= 0) begin
                held++;
                if (held == 1) begin
                    check_val("rr_grant_seq", 32'(grant), 32'(exp_g[seen]));
                    check_val("rr_msel_seq", 32'(msel), 32'(exp_m[seen]));
                    seen++;
                end
                if (held == 2) rel = 3'(1 << m_owner);
            end else begin
                held = 0;
            end
        end
        check_val("rr_owners_seen", 32'(seen), 32'd4);
        req = 3'b000;
        repeat (3) cycle();

        // release pulse from a non-owner is ignored
        req = 3'b001;
        cycle();
        rel = 3'b100;
        cycle();
        check_val("nonowner_rel_grant", 32'(grant), 32'h1);
        check_val("nonowner_rel_terr", 32'(timeout_err), 32'h0);
        req = 3'b000;
        repeat (3) cycle();

        // single requester never releases: forced release after TIMEOUT cycles, then re-grant
        req = 3'b010;
        cycle();
        check_val("to_first_grant", 32'(grant), 32'h2);
        n_hi   = 1;
        n_terr = 0;
        for (int c = 0; c < TIMEOUT + 1; c++) begin
            cycle();
            if (timeout_err) n_terr++;
            else if (n_terr == 0 && grant == 3'b010) n_hi++;
        end
        check_val("to_hold_cycles", 32'(n_hi), 32'(TIMEOUT));
        check_val("to_pulse_count", 32'(n_terr), 32'd1);
        check_val("to_regrant", 32'(grant), 32'h2);
        check_val("to_regrant_msel", 32'(msel), 32'h1);
        req = 3'b000;
        repeat (3) cycle();

        // release and split together: release wins, master 0 is not parked
        req = 3'b001;
        cycle();
        rel   = 3'b001;
        split = 1'b1;
        cycle();
        cycle();
        check_val("rel_split_regrant", 32'(grant), 32'h1);
        req = 3'b000;
        repeat (3) cycle();

`ifdef BUS_ARB_SPLIT_EN
        // split parks master 0, ready brings it back ahead of pending master 2
        req = 3'b001;
        cycle();
        req   = 3'b011;
        split = 1'b1;
        cycle();
        check_val("split_dead_cycle", 32'(grant), 32'h0);
        cycle();
        check_val("split_next_owner", 32'(grant), 32'h2);
        req = 3'b111;
        cycle();
        rel         = 3'b010;
        split_ready = 1'b1;
        cycle();
        cycle();
        check_val("resume_parked", 32'(grant), 32'h1);
`else
        // split and split_ready have no effect in the plain build
        req = 3'b001;
        cycle();
        req   = 3'b011;
        split = 1'b1;
        cycle();
        check_val("split_ignored", 32'(grant), 32'h1);
        split_ready = 1'b1;
        cycle();
        check_val("ready_ignored", 32'(grant), 32'h1);
`endif
        req = 3'b000;
        repeat (3) cycle();

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req = req ^ 3'(1 << b);
            end
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) rel = 3'(1 << m_owner);
            if ($urandom_range(0, 15) == 0) rel = rel | 3'($urandom_range(0, 7));
            split       = ($urandom_range(0, 7) == 0);
            split_ready = ($urandom_range(0, 5) == 0);
            cycle();
        end

        // settle: drop all requests and unpark anything left parked
        req = 3'b000;
        cycle();
        split_ready = 1'b1;
        repeat (4) cycle();

        // asynchronous reset while master 2 owns the bus
        req = 3'b100;
        for (int c = 0; c < 10 && m_owner != 2; c++) cycle();
        check_val("rst_setup_owner", 32'(grant), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_grant", 32'(grant), 32'h0);
        check_val("async_rst_msel", 32'(msel), 32'h0);
        check_val("async_rst_busy", 32'(bus_busy), 32'h0);
        req = 3'b101;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_val("post_rst_first", 32'(grant), 32'h1);
        check_val("post_rst_msel", 32'(msel), 32'h0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
